exit_token_checker: RTL
=======================

# exit_token_checker

Exit-gate counterpart of the entry-side token generation. It accepts a 3-bit token from the exit keypad, recovers the park number as `token ^ pattern` (XOR is self-inverse), and checks that spot against the occupancy vector. A valid token frees the spot and opens the barrier for a fixed time. Repeated invalid tokens lock the gate until a supervisor unlock.

## Interface
Parameters:
- `GATE_CYCLES`, default 4: cycles `gate_open` stays high per valid exit; must be ≥1.
- `MAX_FAILS`, default 3: consecutive rejects that force lockout; must be ≥1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `token_valid` in 1: keypad presents `token`.
- `token` in 3: exit token.
- `token_ready` out 1: block can accept a token.
- `pattern` in 3: shared secret, same value used at entry.
- `occupied` in 8: bit i high means spot i is occupied.
- `release` out 1: one-cycle strobe that frees a spot.
- `release_number` out 3: spot being freed; meaningful while `release` is high.
- `gate_open` out 1: barrier open.
- `reject` out 1: one-cycle strobe for an invalid token.
- `alarm` out 1: lockout indicator.
- `unlock` in 1: supervisor clear of lockout.

## Operation
- States:
  - IDLE: `token_ready`=1.
  - CHECK: all outputs low.
  - OPEN: `gate_open`=1; `release`=1 on the first OPEN cycle only.
  - REJECT: `reject`=1, exactly one cycle.
  - LOCK: `alarm`=1.
- `token_ready` = (state==IDLE) && !rst. Outside IDLE, `token_valid` is ignored and no tokens are queued.
- Acceptance edge (IDLE, `token_valid` && `token_ready`): register `park_q = token ^ pattern`; go to CHECK. `pattern` is sampled only at this edge.
- CHECK edge: `occupied` is sampled at this edge, never earlier.
  - If `occupied[park_q]`: go to OPEN, load gate counter with `GATE_CYCLES`, clear fail count, set `release_number = park_q`.
  - Otherwise: increment fail count. If the new count equals `MAX_FAILS`, go to LOCK; else go to REJECT.
- OPEN: counter decrements each cycle; on the cycle it reaches 1, next state is IDLE.
- REJECT → IDLE after one cycle. Fail count persists across tokens until a valid token, an unlock, or reset.
- LOCK: stays until an edge with `unlock`=1, then goes to IDLE and clears fail count. `unlock` in any other state has no effect.
- The block never modifies `occupied`. The occupancy owner clears the bit on `release`.
- Widths: fail counter `$clog2(MAX_FAILS+1)`, gate counter `$clog2(GATE_CYCLES+1)`, both saturating-safe. Park index is 3 bits; all 8 values are legal.

## Timing
- Reset value: state IDLE, fail count 0, gate counter 0. `release`, `release_number`, `gate_open`, `reject`, `alarm` are all 0. `token_ready` is 0 during `rst`, and 1 in the first cycle after `rst` falls.
- For a token accepted at edge k:
  - CHECK occupies cycle k..k+1.
  - Valid: `release` and `gate_open` rise at k+2. `release` falls at k+3. `gate_open` falls at k+2+GATE_CYCLES. `token_ready` rises at that same edge.
  - Invalid: `reject` is high for k+2..k+3 and `token_ready` rises at k+3. If the lockout threshold is hit, `alarm` rises at k+2 instead.
- All outputs except `token_ready` are registered. `token_ready` is decoded from the state register.
- Reset mid-operation: at the reset edge, `gate_open` falls, a pending `release` is never issued, the fail count is zeroed, and `alarm` clears.
- `unlock` and `token_valid` in the same LOCK cycle: the block unlocks and the token is not accepted. The token can be accepted next cycle.

## Structure
- Shared package `parking_pkg`:
  - `PARK_W`=3, `NUM_SPOTS`=8.
  - `exit_state_t` enum (IDLE, CHECK, OPEN, REJECT, LOCK).
  - Reused by the entry-side blocks.
- One sub-module, `gate_timer`: loadable down-counter. Inputs: `load`, `GATE_CYCLES`. Output: `done` when the count reaches 1. It is instantiated once.
- The FSM, the fail counter and the XOR decode live in `exit_token_checker`.

## Test plan
- Valid exit: pattern=3'b101, token=3'b111, occupied=8'h04 → `release` at k+2 with `release_number`=2; `gate_open` high exactly 4 cycles; `token_ready` back at k+6.
- Empty spot: pattern=3'b101, token=3'b111, occupied=8'h00 → `reject` one cycle at k+2, no `release`, `gate_open` stays 0, `token_ready` at k+3.
- Lockout: three consecutive invalid tokens → the third raises `alarm` instead of `reject`; `token_valid` held high in LOCK is never accepted; `unlock`=1 → IDLE, and the next valid token succeeds.
- Fail-count clear: invalid, invalid, valid (park 0, token = pattern), invalid → no lockout; the fail count after the last token is 1.
- Mid-operation reset: `rst` asserted at cycle 2 of OPEN → `gate_open` 0 from the next edge; all outputs at reset values; `token_ready`=1 one cycle after `rst` falls.
- Edge index: pattern=3'b000, token=3'b111, occupied=8'h80 → `release_number`=7. Also check that `token_valid` during OPEN is ignored and no second `release` occurs.

Source files
------------

// File: rtl/parking_pkg.sv
// ============================================================================
// Module   : parking_pkg
// Brief    : Shared widths and state encoding for the parking entry/exit gates.
// Revision : 1.0
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam int PARK_W    = 3;
    localparam int NUM_SPOTS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        OPEN   = 3'd2,
        REJECT = 3'd3,
        LOCK   = 3'd4
    } exit_state_t;

endpackage

`default_nettype wire

// File: rtl/gate_timer.sv
// ============================================================================
// Module   : gate_timer
// Brief    : Loadable down-counter timing how long the exit barrier stays open.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gate_timer #(
    parameter int GATE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam int CNT_W = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_load_val = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Decrement stops at zero so an idle timer never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign o_done = (r_cnt == c_one);

endmodule

`default_nettype wire

// File: rtl/exit_token_checker.sv
// ============================================================================
// Module   : exit_token_checker
// Brief    : Exit gate: decodes token to park number, frees the spot, opens
//            the barrier, and locks out after repeated invalid tokens.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exit_token_checker
    import parking_pkg::*;
#(
    parameter int GATE_CYCLES = 4,
    parameter int MAX_FAILS   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_token_valid,
    input  logic [PARK_W-1:0]    i_token,
    output logic                 o_token_ready,
    input  logic [PARK_W-1:0]    i_pattern,
    input  logic [NUM_SPOTS-1:0] i_occupied,
    output logic                 o_release,
    output logic [PARK_W-1:0]    o_release_number,
    output logic                 o_gate_open,
    output logic                 o_reject,
    output logic                 o_alarm,
    input  logic                 i_unlock
);

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam logic [FAIL_W-1:0] c_max_fails = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W-1:0] c_fail_one  = FAIL_W'(1);

    exit_state_t        r_state;
    exit_state_t        w_next;
    logic               r_check_first;
    logic [PARK_W-1:0]  r_park;
    logic [FAIL_W-1:0]  r_fail;
    logic [FAIL_W-1:0]  w_fail_next;
    logic [FAIL_W-1:0]  w_fail_inc;
    logic               w_accept;
    logic               w_load;
    logic               w_done;
    logic               r_release;
    logic [PARK_W-1:0]  r_release_number;
    logic               r_gate_open;
    logic               r_reject;
    logic               r_alarm;

    assign o_token_ready = (r_state == IDLE) && !rst;
    assign w_accept      = i_token_valid && o_token_ready;
    assign w_fail_inc    = r_fail + c_fail_one;

    gate_timer #(
        .GATE_CYCLES (GATE_CYCLES)
    ) u_gate_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_en   (r_state == OPEN),
        .o_done (w_done)
    );

    // CHECK spans two cycles; occupancy is judged only on its second edge.
    always_comb begin
        w_next      = r_state;
        w_fail_next = r_fail;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = CHECK;
            end
            CHECK: begin
                if (!r_check_first) begin
                    if (i_occupied[r_park]) begin
                        w_next      = OPEN;
                        w_load      = 1'b1;
                        w_fail_next = '0;
                    end else begin
                        w_fail_next = (r_fail == c_max_fails) ? r_fail : w_fail_inc;
                        w_next      = (w_fail_inc == c_max_fails) ? LOCK : REJECT;
                    end
                end
            end
            OPEN: begin
                if (w_done) w_next = IDLE;
            end
            REJECT: begin
                w_next = IDLE;
            end
            LOCK: begin
                if (i_unlock) begin
                    w_next      = IDLE;
                    w_fail_next = '0;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_check_first    <= 1'b0;
            r_park           <= '0;
            r_fail           <= '0;
            r_release        <= 1'b0;
            r_release_number <= '0;
            r_gate_open      <= 1'b0;
            r_reject         <= 1'b0;
            r_alarm          <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_check_first <= w_accept;
            r_fail        <= w_fail_next;
            if (w_accept) r_park <= i_token ^ i_pattern;
            // Outputs are registered from the next state so they align with it.
            r_release   <= (r_state == CHECK) && (w_next == OPEN);
            if ((r_state == CHECK) && (w_next == OPEN)) r_release_number <= r_park;
            r_gate_open <= (w_next == OPEN);
            r_reject    <= (w_next == REJECT);
            r_alarm     <= (w_next == LOCK);
        end
    end

    assign o_release        = r_release;
    assign o_release_number = r_release_number;
    assign o_gate_open      = r_gate_open;
    assign o_reject         = r_reject;
    assign o_alarm          = r_alarm;

endmodule

`default_nettype wire
